reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Tracks destination registers of in-flight long-latency writebacks: multicycle data-cache loads and MUL/DIV results.
- Stalls the ID stage when the decoding instruction depends on an unfinished result.
- Complements the EX/MEM and MEM/WB forwarding logic, which covers only fixed-latency producers. Also generates the classic one-bubble load-use stall.
- Sits beside the ID stage. stall_o drives PC write-disable, IF/ID hold and the ID/EX bubble insert.

Parameters:
- MAX_OUT, 4, maximum simultaneously outstanding long-latency writebacks (1..15).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- IFID_valid_i  in  1  ID stage holds a real instruction (not a bubble).
- IFID_rs1_i  in  5  source register 1 of the ID instruction.
- IFID_rs2_i  in  5  source register 2 of the ID instruction.
- IFID_rd_i  in  5  destination register of the ID instruction.
- IFID_use_rs1_i  in  1  ID instruction reads rs1.
- IFID_use_rs2_i  in  1  ID instruction reads rs2.
- IFID_RegWrite_i  in  1  ID instruction writes rd.
- IFID_long_i  in  1  ID instruction is long-latency (writes back via the wb_* port).
- IDEX_MemRead_i  in  1  EX-stage instruction is an ordinary load.
- IDEX_rd_i  in  5  EX-stage destination register.
- wb_valid_i  in  1  a long-latency result is written to the register file this cycle.
- wb_rd_i  in  5  register written by that result.
- stall_o  out  1  hold PC and IF/ID, insert bubble into ID/EX.
- pending_o  out  32  registered pending-write bitmask, bit n = xn.
- outstanding_o  out  4  number of pending long-latency writebacks.
- stall_cnt_o  out  CNT_W  cycles with stall_o high, saturating.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_i low, asynchronous): pending_o=0, outstanding_o=0, stall_cnt_o=0, err_o=0. stall_o is combinational, so it reads 0 while IFID_valid_i=0.
- stall_o = IFID_valid_i AND (raw OR waw OR full OR loaduse), where:
  - raw = (use_rs1 AND rs1!=0 AND pending[rs1]) OR (use_rs2 AND rs2!=0 AND pending[rs2]).
  - waw = RegWrite AND rd!=0 AND pending[rd].
  - full = IFID_long_i AND RegWrite AND rd!=0 AND outstanding==MAX_OUT.
  - loaduse = IDEX_MemRead_i AND IDEX_rd_i!=0 AND ((use_rs1 AND IDEX_rd_i==rs1) OR (use_rs2 AND IDEX_rd_i==rs2)).
- Stall terms use registered pending only. A writeback does not release a stall in the same cycle; release occurs the following cycle.
- Issue = IFID_valid_i AND IFID_long_i AND IFID_RegWrite_i AND IFID_rd_i!=0 AND !stall_o. On issue, the next edge sets pending[rd] and increments outstanding.
- Long instructions with rd=0 or RegWrite=0 are not tracked.
- Writeback (wb_valid_i AND wb_rd_i!=0):
  - If pending[wb_rd] is set: next edge clears it and decrements outstanding.
  - If pending[wb_rd] is clear: no state change, err_o set.
  - wb_rd_i=0 with wb_valid_i: ignored.
- Simultaneous issue and writeback: both apply, so outstanding is unchanged. They cannot target the same register, because the waw term blocks that issue.
- outstanding never exceeds MAX_OUT and never underflows.
- stall_cnt_o increments on every edge with stall_o=1 and saturates at all-ones.
- err_o clears only on reset.
- pending[0] is constantly 0.

Test Plan:
- Reset mid-operation: pending=0x0000_0020, outstanding=1; pulse rst_i low asynchronously -> pending_o=0, outstanding_o=0, stall_cnt_o=0, err_o=0 before the next edge.
- Load-use: IDEX_MemRead=1, IDEX_rd=5; ID instruction uses rs1=5 -> stall_o=1 for exactly 1 cycle, stall_cnt_o=1. Repeat with rs1=0, IDEX_rd=0 -> no stall.
- RAW on long op:
  - Issue long rd=7 -> pending_o=0x80, outstanding_o=1.
  - Next instruction uses rs2=7 -> stall_o held until wb_valid=1, wb_rd=7; stall_o drops one cycle after the writeback.
  - pending_o=0 afterwards.
- Full and WAW:
  - MAX_OUT=4: issue long rd=1,2,3,4 -> outstanding_o=4.
  - Fifth long issue (rd=9) stalls.
  - A non-long instruction writing rd=2 stalls via waw.
  - Writeback of x1 -> rd=9 issues one cycle later.
- Simultaneous issue and writeback: pending x3; issue long rd=6 while wb_rd=3 -> pending_o=0x40, outstanding_o unchanged at 1.
- Error and saturation: wb_valid with wb_rd=12 not pending -> err_o=1 sticky, state unchanged. With CNT_W=4, hold a stall for 20 cycles -> stall_cnt_o=15.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_if
// Bundles the ID-stage hazard-query signals, the EX-stage load information,
// the long-latency writeback port and the scoreboard status outputs.
//
// Modports:
//   master - pipeline side: drives the ID/EX/WB information, observes the
//            stall, pending mask, outstanding count, stall counter and error.
//   slave  - scoreboard side: the reverse directions.
//
// Parameter:
//   CNT_W  - width of the stall performance counter (must match the
//            scoreboard instance).
// -----------------------------------------------------------------------------
interface reg_scoreboard_if #(
  parameter int CNT_W = 16
);
  // ID stage instruction
  logic             IFID_valid_i;
  logic [4:0]       IFID_rs1_i;
  logic [4:0]       IFID_rs2_i;
  logic [4:0]       IFID_rd_i;
  logic             IFID_use_rs1_i;
  logic             IFID_use_rs2_i;
  logic             IFID_RegWrite_i;
  logic             IFID_long_i;
  // EX stage ordinary load
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_rd_i;
  // Long-latency writeback
  logic             wb_valid_i;
  logic [4:0]       wb_rd_i;
  // Status
  logic             stall_o;
  logic [31:0]      pending_o;
  logic [3:0]       outstanding_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             err_o;

  modport master (
    output IFID_valid_i, IFID_rs1_i, IFID_rs2_i, IFID_rd_i,
           IFID_use_rs1_i, IFID_use_rs2_i, IFID_RegWrite_i, IFID_long_i,
           IDEX_MemRead_i, IDEX_rd_i, wb_valid_i, wb_rd_i,
    input  stall_o, pending_o, outstanding_o, stall_cnt_o, err_o
  );

  modport slave (
    input  IFID_valid_i, IFID_rs1_i, IFID_rs2_i, IFID_rd_i,
           IFID_use_rs1_i, IFID_use_rs2_i, IFID_RegWrite_i, IFID_long_i,
           IDEX_MemRead_i, IDEX_rd_i, wb_valid_i, wb_rd_i,
    output stall_o, pending_o, outstanding_o, stall_cnt_o, err_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Register scoreboard beside the ID stage. Tracks destination registers of
// in-flight long-latency producers (multicycle loads, MUL/DIV) and stalls the
// ID instruction on RAW/WAW against them, when the tracking capacity is
// exhausted, or on the classic one-bubble load-use hazard.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - reg_scoreboard_if.slave: ID query, EX load info, writeback port,
//            stall_o (combinational), pending_o / outstanding_o /
//            stall_cnt_o / err_o (registered)
//
// Parameters:
//   MAX_OUT - maximum simultaneously outstanding long writebacks (1..15)
//   CNT_W   - stall counter width
// -----------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  reg_scoreboard_if.slave   bus
);

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  logic [31:0]      r_pending;
  logic [3:0]       r_outstanding;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_err;

  logic        w_raw;
  logic        w_waw;
  logic        w_full;
  logic        w_loaduse;
  logic        w_stall;
  logic        w_issue;
  logic        w_wb_act;
  logic        w_wb_hit;
  logic        w_wb_err;
  logic [31:0] w_pending_next;
  logic [3:0]  w_outstanding_next;

  // Hazard terms look only at the registered pending mask, so a writeback
  // arriving this cycle releases a dependent instruction on the next cycle.
  assign w_raw = (bus.IFID_use_rs1_i && (bus.IFID_rs1_i != 5'd0) && r_pending[bus.IFID_rs1_i]) ||
                 (bus.IFID_use_rs2_i && (bus.IFID_rs2_i != 5'd0) && r_pending[bus.IFID_rs2_i]);

  assign w_waw = bus.IFID_RegWrite_i && (bus.IFID_rd_i != 5'd0) && r_pending[bus.IFID_rd_i];

  assign w_full = bus.IFID_long_i && bus.IFID_RegWrite_i && (bus.IFID_rd_i != 5'd0) &&
                  (r_outstanding == MAX_OUT_C);

  assign w_loaduse = bus.IDEX_MemRead_i && (bus.IDEX_rd_i != 5'd0) &&
                     ((bus.IFID_use_rs1_i && (bus.IDEX_rd_i == bus.IFID_rs1_i)) ||
                      (bus.IFID_use_rs2_i && (bus.IDEX_rd_i == bus.IFID_rs2_i)));

  assign w_stall = bus.IFID_valid_i && (w_raw || w_waw || w_full || w_loaduse);

  // Only long ops that really write a non-zero register are tracked.
  assign w_issue = bus.IFID_valid_i && bus.IFID_long_i && bus.IFID_RegWrite_i &&
                   (bus.IFID_rd_i != 5'd0) && !w_stall;

  assign w_wb_act = bus.wb_valid_i && (bus.wb_rd_i != 5'd0);
  assign w_wb_hit = w_wb_act && r_pending[bus.wb_rd_i];
  assign w_wb_err = w_wb_act && !r_pending[bus.wb_rd_i];

  // Per-register next state. x0 is never tracked. An issue and a writeback
  // in the same cycle cannot name the same register (the WAW term blocks
  // that issue), so set and clear never collide.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign w_pending_next[gi] = 1'b0;
      end else begin : g_reg
        assign w_pending_next[gi] =
          (r_pending[gi] && !(w_wb_hit && (bus.wb_rd_i == 5'(gi)))) ||
          (w_issue && (bus.IFID_rd_i == 5'(gi)));
      end
    end
  endgenerate

  // Issue and matching writeback together leave the count unchanged.
  always_comb begin
    w_outstanding_next = r_outstanding;
    case ({w_issue, w_wb_hit})
      2'b10:   w_outstanding_next = r_outstanding + 4'd1;
      2'b01:   w_outstanding_next = r_outstanding - 4'd1;
      default: w_outstanding_next = r_outstanding;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pending     <= 32'd0;
      r_outstanding <= 4'd0;
      r_stall_cnt   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_pending     <= w_pending_next;
      r_outstanding <= w_outstanding_next;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      // Writeback to a register that is not pending is a protocol error;
      // the flag is sticky until reset.
      if (w_wb_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.stall_o       = w_stall;
  assign bus.pending_o     = r_pending;
  assign bus.outstanding_o = r_outstanding;
  assign bus.stall_cnt_o   = r_stall_cnt;
  assign bus.err_o         = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed scenarios followed by random traffic. Each driven cycle pushes the
// expected stall/status into a queue computed from a reference model that
// keeps the in-flight destination registers as a plain list; a monitor pops
// and compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

  localparam int MAX_OUT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk_i;
  logic rst_i;

  reg_scoreboard_if #(.CNT_W(CNT_W)) bus ();

  reg_scoreboard #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        stall;
    logic [31:0] pend;
    int          outs;
    int          cnt;
    logic        err;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_txn    = 0;

  // Reference model state
  int   inflight[$];
  int   cnt_m = 0;
  bit   err_m = 1'b0;

  function automatic bit in_flight(int r);
    if (r == 0) return 1'b0;
    foreach (inflight[k]) if (inflight[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = 32'd0;
    foreach (inflight[k]) m[inflight[k]] = 1'b1;
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one transaction per falling edge while expectations are queued.
  always @(negedge clk_i) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_txn++;
      $display("txn %0d %s stall=%0b pend=0x%08h out=%0d cnt=%0d err=%0b",
               n_txn, e.tag, bus.stall_o, bus.pending_o, bus.outstanding_o,
               bus.stall_cnt_o, bus.err_o);
      chk({e.tag, ".stall"}, {31'd0, bus.stall_o}, {31'd0, e.stall});
      chk({e.tag, ".pending"}, bus.pending_o, e.pend);
      chk({e.tag, ".outstanding"}, {28'd0, bus.outstanding_o}, 32'(e.outs));
      chk({e.tag, ".stall_cnt"}, {{(32-CNT_W){1'b0}}, bus.stall_cnt_o}, 32'(e.cnt));
      chk({e.tag, ".err"}, {31'd0, bus.err_o}, {31'd0, e.err});
    end
  end

  task automatic set_id(bit v, int rs1, int rs2, int rd, bit u1, bit u2, bit rw, bit lng);
    bus.IFID_valid_i    = v;
    bus.IFID_rs1_i      = 5'(rs1);
    bus.IFID_rs2_i      = 5'(rs2);
    bus.IFID_rd_i       = 5'(rd);
    bus.IFID_use_rs1_i  = u1;
    bus.IFID_use_rs2_i  = u2;
    bus.IFID_RegWrite_i = rw;
    bus.IFID_long_i     = lng;
  endtask

  task automatic set_ex(bit mr, int rd);
    bus.IDEX_MemRead_i = mr;
    bus.IDEX_rd_i      = 5'(rd);
  endtask

  task automatic set_wb(bit v, int rd);
    bus.wb_valid_i = v;
    bus.wb_rd_i    = 5'(rd);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_ex(0, 0);
    set_wb(0, 0);
  endtask

  // Evaluate the hazard rules on the current inputs, queue the expectation,
  // advance the model across the coming edge, then move to just after it.
  task automatic step(string tag);
    exp_t e;
    int  rs1, rs2, rd, xrd, wrd;
    bit  raw, waw, full, lu, st, iss, wbv;
    rs1 = int'(bus.IFID_rs1_i);
    rs2 = int'(bus.IFID_rs2_i);
    rd  = int'(bus.IFID_rd_i);
    xrd = int'(bus.IDEX_rd_i);
    wrd = int'(bus.wb_rd_i);
    wbv = bus.wb_valid_i;
    raw  = (bus.IFID_use_rs1_i && in_flight(rs1)) || (bus.IFID_use_rs2_i && in_flight(rs2));
    waw  = bus.IFID_RegWrite_i && in_flight(rd);
    full = bus.IFID_long_i && bus.IFID_RegWrite_i && (rd != 0) && (inflight.size() == MAX_OUT);
    lu   = bus.IDEX_MemRead_i && (xrd != 0) &&
           ((bus.IFID_use_rs1_i && xrd == rs1) || (bus.IFID_use_rs2_i && xrd == rs2));
    st   = bus.IFID_valid_i && (raw || waw || full || lu);
    iss  = bus.IFID_valid_i && bus.IFID_long_i && bus.IFID_RegWrite_i && (rd != 0) && !st;
    e.stall = st;
    e.pend  = model_mask();
    e.outs  = inflight.size();
    e.cnt   = cnt_m;
    e.err   = err_m;
    e.tag   = tag;
    q.push_back(e);
    if (wbv && wrd != 0) begin
      if (in_flight(wrd)) begin
        foreach (inflight[k]) if (inflight[k] == wrd) begin inflight.delete(k); break; end
      end else begin
        err_m = 1'b1;
      end
    end
    if (iss) inflight.push_back(rd);
    if (st && cnt_m < CNT_MAX) cnt_m++;
    @(posedge clk_i);
    #1;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear immediately.
  task automatic async_reset(string tag);
    idle();
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk({tag, ".pending"}, bus.pending_o, 32'd0);
    chk({tag, ".outstanding"}, {28'd0, bus.outstanding_o}, 32'd0);
    chk({tag, ".stall_cnt"}, {{(32-CNT_W){1'b0}}, bus.stall_cnt_o}, 32'd0);
    chk({tag, ".err"}, {31'd0, bus.err_o}, 32'd0);
    chk({tag, ".stall"}, {31'd0, bus.stall_o}, 32'd0);
    #1 rst_i = 1'b1;
    inflight.delete();
    cnt_m = 0;
    err_m = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  function automatic int pick_reg();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 7));
  endfunction

  task automatic rand_cycle();
    int r1, r2, rd;
    r1 = pick_reg();
    r2 = pick_reg();
    rd = pick_reg();
    set_id($urandom_range(0, 7) != 0, r1, r2, rd, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    set_ex($urandom_range(0, 4) == 0, pick_reg());
    if (inflight.size() > 0 && $urandom_range(0, 2) == 0)
      set_wb(1, inflight[$urandom_range(0, inflight.size() - 1)]);
    else if ($urandom_range(0, 49) == 0)
      set_wb(1, pick_reg());
    else
      set_wb($urandom_range(0, 9) == 0, 0);
    step("rand");
  endtask

  initial begin
    rst_i = 1'b0;
    idle();
    repeat (2) @(negedge clk_i);
    chk("reset.pending", bus.pending_o, 32'd0);
    chk("reset.outstanding", {28'd0, bus.outstanding_o}, 32'd0);
    chk("reset.stall_cnt", {{(32-CNT_W){1'b0}}, bus.stall_cnt_o}, 32'd0);
    chk("reset.err", {31'd0, bus.err_o}, 32'd0);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Load-use: one bubble, then the load has moved on.
    set_id(1, 5, 0, 8, 1, 0, 1, 0); set_ex(1, 5); step("lu_hit");
    set_ex(0, 0); step("lu_after");
    chk("lu.stall_cnt", {{(32-CNT_W){1'b0}}, bus.stall_cnt_o}, 32'd1);
    set_id(1, 0, 0, 8, 1, 0, 1, 0); set_ex(1, 0); step("lu_x0");
    idle(); step("idle");

    // RAW against a long op, released the cycle after its writeback.
    set_id(1, 0, 0, 7, 0, 0, 1, 1); step("raw_issue7");
    chk("raw.pending", bus.pending_o, 32'h0000_0080);
    chk("raw.outstanding", {28'd0, bus.outstanding_o}, 32'd1);
    set_id(1, 1, 7, 10, 0, 1, 1, 0);
    repeat (3) step("raw_wait");
    set_wb(1, 7); step("raw_wb");
    set_wb(0, 0); step("raw_release");
    chk("raw.pending_after", bus.pending_o, 32'd0);

    // Capacity limit and WAW.
    for (int r = 1; r <= 4; r++) begin
      set_id(1, 0, 0, r, 0, 0, 1, 1); step("full_issue");
    end
    chk("full.outstanding", {28'd0, bus.outstanding_o}, 32'd4);
    set_id(1, 0, 0, 9, 0, 0, 1, 1); step("full_stall9");
    set_id(1, 0, 0, 2, 0, 0, 1, 0); step("waw_rd2");
    set_id(1, 0, 0, 9, 0, 0, 1, 1); set_wb(1, 1); step("full_wb1");
    set_wb(0, 0); step("full_issue9");
    chk("full.pending9", bus.pending_o, 32'h0000_021C);
    chk("full.outstanding9", {28'd0, bus.outstanding_o}, 32'd4);
    idle();
    set_wb(1, 2); step("drain"); set_wb(1, 3); step("drain");
    set_wb(1, 4); step("drain"); set_wb(1, 9); step("drain");
    chk("drain.outstanding", {28'd0, bus.outstanding_o}, 32'd0);

    // Simultaneous issue and writeback.
    idle(); set_id(1, 0, 0, 3, 0, 0, 1, 1); step("sim_issue3");
    set_id(1, 0, 0, 6, 0, 0, 1, 1); set_wb(1, 3); step("sim_both");
    chk("sim.pending", bus.pending_o, 32'h0000_0040);
    chk("sim.outstanding", {28'd0, bus.outstanding_o}, 32'd1);
    idle(); set_wb(1, 6); step("sim_drain");

    // Saturating stall counter.
    idle(); set_id(1, 0, 0, 7, 0, 0, 1, 1); step("sat_issue7");
    set_id(1, 7, 0, 11, 1, 0, 1, 0);
    repeat (20) step("sat_hold");
    chk("sat.stall_cnt", {{(32-CNT_W){1'b0}}, bus.stall_cnt_o}, 32'(CNT_MAX));
    idle(); set_wb(1, 7); step("sat_drain");

    // Writeback to a register that is not pending.
    idle(); set_wb(1, 12); step("err_wb12");
    set_wb(0, 0); step("err_sticky");
    chk("err.flag", {31'd0, bus.err_o}, 32'd1);
    chk("err.pending", bus.pending_o, 32'd0);
    set_wb(1, 0); step("wb_x0");

    // Reset mid-operation.
    idle(); set_id(1, 0, 0, 5, 0, 0, 1, 1); step("mid_issue5");
    chk("mid.pending", bus.pending_o, 32'h0000_0020);
    async_reset("mid_reset");

    // Random traffic, with a reset in the middle.
    for (int i = 0; i < 300; i++) rand_cycle();
    async_reset("rand_reset");
    for (int i = 0; i < 300; i++) rand_cycle();
    idle();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk_i);
    if (q.size() > 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
